// File: rtl/conv_win_ctrl.sv
// conv_win_ctrl: tracks raster position of accepted pixels and flags every
// pixel that closes a stride-aligned WS x WS window (bottom-right corner),
// reporting its output-map coordinate plus start/end-of-frame markers.
module conv_win_ctrl #(
  parameter int XW     = 32,
  parameter int XH     = 32,
  parameter int WS     = 5,
  parameter int STRIDE = 1,
  parameter int CW     = 6
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iValid,
  input  logic          iClear,
  output logic          oValid,
  output logic [CW-1:0] oRow,
  output logic [CW-1:0] oCol,
  output logic          oSof,
  output logic          oEof,
  output logic          oFrameDone,
  output logic          oBusy
);

  localparam int OW = (XW - WS) / STRIDE + 1;
  localparam int OH = (XH - WS) / STRIDE + 1;

  localparam logic [CW-1:0] X_END  = CW'(XW - 1);
  localparam logic [CW-1:0] Y_END  = CW'(XH - 1);
  // Last column/row that can still hold a full stride-aligned window
  localparam logic [CW-1:0] X_LAST = CW'(WS - 1 + (OW - 1) * STRIDE);
  localparam logic [CW-1:0] Y_LAST = CW'(WS - 1 + (OH - 1) * STRIDE);
  localparam logic [CW-1:0] WS_M1  = CW'(WS - 1);
  localparam logic [CW-1:0] STEP   = CW'(STRIDE);
  localparam logic [CW-1:0] OW_M1  = CW'(OW - 1);
  localparam logic [CW-1:0] OH_M1  = CW'(OH - 1);

  typedef enum logic {IDLE, RUN} stateT;

  stateT         state;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [CW-1:0] xn;
  logic [CW-1:0] yn;
  logic [CW-1:0] rowCnt;
  logic [CW-1:0] colCnt;
  logic          accept;
  logic          rowEnd;
  logic          frameEnd;
  logic          hit;
  logic          hitRow;

  // A clear on the same cycle drops the pixel entirely
  assign accept   = iValid && !iClear;
  assign rowEnd   = (x == X_END);
  assign frameEnd = rowEnd && (y == Y_END);
  // Targets stop advancing at the last aligned position, so a plain equality
  // is enough: once x or y passes the final target no further hits occur.
  assign hit      = (x == xn) && (y == yn);
  assign hitRow   = (y == yn);

  // Pixel position counters and the next-window target counters
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      x      <= '0;
      y      <= '0;
      xn     <= WS_M1;
      yn     <= WS_M1;
      rowCnt <= '0;
      colCnt <= '0;
    end else if (iClear) begin
      x      <= '0;
      y      <= '0;
      xn     <= WS_M1;
      yn     <= WS_M1;
      rowCnt <= '0;
      colCnt <= '0;
    end else if (iValid) begin
      if (rowEnd) begin
        x      <= '0;
        xn     <= WS_M1;
        colCnt <= '0;
        if (frameEnd) begin
          y      <= '0;
          yn     <= WS_M1;
          rowCnt <= '0;
        end else begin
          y <= y + CW'(1);
          if (hitRow && (yn != Y_LAST)) begin
            yn     <= yn + STEP;
            rowCnt <= rowCnt + CW'(1);
          end
        end
      end else begin
        x <= x + CW'(1);
        if (hit) begin
          colCnt <= colCnt + CW'(1);
          if (xn != X_LAST) begin
            xn <= xn + STEP;
          end
        end
      end
    end
  end

  // Registered window flag and coordinates; coordinates hold between hits
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oValid <= 1'b0;
      oRow   <= '0;
      oCol   <= '0;
      oSof   <= 1'b0;
      oEof   <= 1'b0;
    end else if (iClear) begin
      oValid <= 1'b0;
      oSof   <= 1'b0;
      oEof   <= 1'b0;
    end else begin
      oValid <= iValid && hit;
      if (iValid && hit) begin
        oRow <= rowCnt;
        oCol <= colCnt;
        oSof <= (rowCnt == '0) && (colCnt == '0);
        oEof <= (rowCnt == OH_M1) && (colCnt == OW_M1);
      end
    end
  end

  // Frame-level FSM: IDLE until the first pixel, RUN until the last one
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state      <= IDLE;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
    end else if (iClear) begin
      state      <= IDLE;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      oFrameDone <= accept && frameEnd;
      case (state)
        IDLE: begin
          if (accept && !frameEnd) begin
            state <= RUN;
            oBusy <= 1'b1;
          end
        end
        RUN: begin
          if (accept && frameEnd) begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_win_ctrl.sv
// tb_conv_win_ctrl: two instances (32x32/WS5/S1 and 8x6/WS3/S2) driven with
// contiguous, gapped, back-to-back, cleared and reset-interrupted frames and
// checked every cycle against a per-pixel-index reference model.
module tb_conv_win_ctrl;

  localparam int MXW[2] = '{32, 8};
  localparam int MXH[2] = '{32, 6};
  localparam int MWS[2] = '{5, 3};
  localparam int MST[2] = '{1, 2};

  typedef struct {
    int idx;
    int row;
    int col;
    bit sof;
    bit eof;
    bit done;
  } pulseT;

  logic       clk;
  logic       rstn;
  logic       vld[2];
  logic       clr[2];
  logic       ov[2];
  logic [5:0] orow[2];
  logic [5:0] ocol[2];
  logic       osof[2];
  logic       oeof[2];
  logic       odone[2];
  logic       obusy[2];

  conv_win_ctrl u0 (
    .iCLK(clk), .iRSTn(rstn), .iValid(vld[0]), .iClear(clr[0]),
    .oValid(ov[0]), .oRow(orow[0]), .oCol(ocol[0]), .oSof(osof[0]),
    .oEof(oeof[0]), .oFrameDone(odone[0]), .oBusy(obusy[0])
  );

  conv_win_ctrl #(.XW(8), .XH(6), .WS(3), .STRIDE(2), .CW(6)) u1 (
    .iCLK(clk), .iRSTn(rstn), .iValid(vld[1]), .iClear(clr[1]),
    .oValid(ov[1]), .oRow(orow[1]), .oCol(ocol[1]), .oSof(osof[1]),
    .oEof(oeof[1]), .oFrameDone(odone[1]), .oBusy(obusy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int pIdx[2] = '{0, 0};
  int nAcc[2] = '{0, 0};
  bit eV[2]   = '{0, 0};
  int eRow[2] = '{0, 0};
  int eCol[2] = '{0, 0};
  bit eSof[2] = '{0, 0};
  bit eEof[2] = '{0, 0};
  bit eDone[2] = '{0, 0};
  bit eBusy[2] = '{0, 0};

  function automatic int owOf(int i);
    return (MXW[i] - MWS[i]) / MST[i] + 1;
  endfunction

  function automatic int ohOf(int i);
    return (MXH[i] - MWS[i]) / MST[i] + 1;
  endfunction

  // Window corner test straight from the alignment rules
  function automatic bit qual(int i, int p);
    int dx;
    int dy;
    dx = p % MXW[i] - MWS[i] + 1;
    dy = p / MXW[i] - MWS[i] + 1;
    return (dx >= 0) && (dy >= 0) && (dx % MST[i] == 0) && (dy % MST[i] == 0)
           && (dx / MST[i] < owOf(i)) && (dy / MST[i] < ohOf(i));
  endfunction

  function automatic int rowOf(int i, int p);
    return (p / MXW[i] - MWS[i] + 1) / MST[i];
  endfunction

  function automatic int colOf(int i, int p);
    return (p % MXW[i] - MWS[i] + 1) / MST[i];
  endfunction

  always @(posedge clk or negedge rstn) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        pIdx[i] <= 0; eV[i] <= 1'b0; eRow[i] <= 0; eCol[i] <= 0;
        eSof[i] <= 1'b0; eEof[i] <= 1'b0; eDone[i] <= 1'b0; eBusy[i] <= 1'b0;
      end else if (clr[i]) begin
        pIdx[i] <= 0; eV[i] <= 1'b0; eSof[i] <= 1'b0; eEof[i] <= 1'b0;
        eDone[i] <= 1'b0; eBusy[i] <= 1'b0;
      end else if (vld[i]) begin
        eV[i] <= qual(i, pIdx[i]);
        if (qual(i, pIdx[i])) begin
          eRow[i] <= rowOf(i, pIdx[i]);
          eCol[i] <= colOf(i, pIdx[i]);
          eSof[i] <= (rowOf(i, pIdx[i]) == 0) && (colOf(i, pIdx[i]) == 0);
          eEof[i] <= (rowOf(i, pIdx[i]) == ohOf(i) - 1) && (colOf(i, pIdx[i]) == owOf(i) - 1);
        end
        eDone[i] <= (pIdx[i] == MXW[i] * MXH[i] - 1);
        eBusy[i] <= (pIdx[i] != MXW[i] * MXH[i] - 1);
        pIdx[i]  <= (pIdx[i] == MXW[i] * MXH[i] - 1) ? 0 : pIdx[i] + 1;
        nAcc[i]  <= nAcc[i] + 1;
      end else begin
        eV[i]    <= 1'b0;
        eDone[i] <= 1'b0;
      end
    end
  end

  // ---------------- checking / monitoring ----------------
  int checks   = 0;
  int failures = 0;
  pulseT pq0[$];
  pulseT pq1[$];
  int doneCnt[2] = '{0, 0};
  int doneAt[2]  = '{-1, -1};
  int busyLow[2] = '{0, 0};

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic pulseT pget(int i, int k);
    pulseT r;
    r.idx = -1; r.row = -1; r.col = -1; r.sof = 1'b0; r.eof = 1'b0; r.done = 1'b0;
    if (i == 0 && k >= 0 && k < pq0.size()) r = pq0[k];
    if (i == 1 && k >= 0 && k < pq1.size()) r = pq1[k];
    return r;
  endfunction

  task automatic compareAndLog();
    pulseT p;
    for (int i = 0; i < 2; i++) begin
      chk("oValid", i, ov[i], eV[i]);
      chk("oFrameDone", i, odone[i], eDone[i]);
      chk("oBusy", i, obusy[i], eBusy[i]);
      if (eV[i]) begin
        chk("oRow", i, orow[i], eRow[i]);
        chk("oCol", i, ocol[i], eCol[i]);
        chk("oSof", i, osof[i], eSof[i]);
        chk("oEof", i, oeof[i], eEof[i]);
      end
      if (ov[i]) begin
        p.idx = nAcc[i] - 1; p.row = orow[i]; p.col = ocol[i];
        p.sof = osof[i]; p.eof = oeof[i]; p.done = odone[i];
        if (i == 0) pq0.push_back(p);
        else pq1.push_back(p);
      end
      if (odone[i]) begin
        doneCnt[i]++;
        doneAt[i] = nAcc[i] - 1;
      end
      if (!obusy[i]) busyLow[i]++;
    end
  endtask

  // One clock: drive inputs, let the edge sample them, check on the falling edge
  task automatic step(input bit v0, input bit c0, input bit v1, input bit c1);
    vld[0] = v0; clr[0] = c0; vld[1] = v1; clr[1] = c1;
    @(posedge clk);
    @(negedge clk);
    compareAndLog();
    $display("cyc t=%0t v=%0b%0b c=%0b%0b ov=%0b%0b row=%0d/%0d col=%0d/%0d done=%0b%0b busy=%0b%0b",
             $time, v0, v1, c0, c1, ov[0], ov[1], orow[0], orow[1], ocol[0], ocol[1],
             odone[0], odone[1], obusy[0], obusy[1]);
  endtask

  task automatic checkZeros(input string name, input int i);
    chk({name, "_oValid"}, i, ov[i], 0);
    chk({name, "_oRow"}, i, orow[i], 0);
    chk({name, "_oCol"}, i, ocol[i], 0);
    chk({name, "_oSof"}, i, osof[i], 0);
    chk({name, "_oEof"}, i, oeof[i], 0);
    chk({name, "_oFrameDone"}, i, odone[i], 0);
    chk({name, "_oBusy"}, i, obusy[i], 0);
  endtask

  // Hand-derived expectations for one full default frame
  task automatic checkBig(input string name, input int bp, input int ba, input int bd);
    pulseT f;
    pulseT l;
    f = pget(0, bp);
    l = pget(0, pq0.size() - 1);
    chk({name, "_pulses"}, 0, pq0.size() - bp, 784);
    chk({name, "_firstIdx"}, 0, f.idx - ba, 132);
    chk({name, "_firstRow"}, 0, f.row, 0);
    chk({name, "_firstCol"}, 0, f.col, 0);
    chk({name, "_firstSof"}, 0, f.sof, 1);
    chk({name, "_lastRow"}, 0, l.row, 27);
    chk({name, "_lastCol"}, 0, l.col, 27);
    chk({name, "_lastEof"}, 0, l.eof, 1);
    chk({name, "_lastDoneWithEof"}, 0, l.done, 1);
    chk({name, "_doneCount"}, 0, doneCnt[0] - bd, 1);
  endtask

  // Hand-derived pulse positions for 8x6/WS3/S2 frames
  task automatic checkSmall(input string name, input int bp, input int ba, input int bd,
                            input int frames);
    int pos[6];
    pulseT p;
    pos = '{18, 20, 22, 34, 36, 38};
    chk({name, "_pulses"}, 1, pq1.size() - bp, 6 * frames);
    for (int k = 0; k < 6 * frames; k++) begin
      p = pget(1, bp + k);
      chk({name, "_idx"}, 1, p.idx - ba, pos[k % 6] + 48 * (k / 6));
      chk({name, "_row"}, 1, p.row, (k % 6) / 3);
      chk({name, "_col"}, 1, p.col, k % 3);
      chk({name, "_sof"}, 1, p.sof, (k % 6) == 0);
      chk({name, "_eof"}, 1, p.eof, (k % 6) == 5);
    end
    chk({name, "_doneCount"}, 1, doneCnt[1] - bd, frames);
    chk({name, "_doneIdx"}, 1, doneAt[1] - ba, 48 * frames - 1);
  endtask

  initial begin
    int bp;
    int ba;
    int bd;
    int bl;
    int got;
    rstn = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0; clr[0] = 1'b0; clr[1] = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checkZeros("reset", 0);
    checkZeros("reset", 1);
    rstn = 1'b1;
    step(0, 0, 0, 0);

    // Scenario 1: one contiguous default frame
    bp = pq0.size(); ba = nAcc[0]; bd = doneCnt[0];
    for (int k = 0; k < 1024; k++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    checkBig("s1", bp, ba, bd);

    // Scenario 2: one contiguous small frame
    bp = pq1.size(); ba = nAcc[1]; bd = doneCnt[1];
    for (int k = 0; k < 48; k++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    checkSmall("s2", bp, ba, bd, 1);

    // Scenario 3: same frame with random gaps
    bp = pq1.size(); ba = nAcc[1]; bd = doneCnt[1];
    got = 0;
    while (got < 48) begin
      if ($urandom_range(0, 1) == 1) begin
        step(0, 0, 1, 0);
        got++;
      end else begin
        step(0, 0, 0, 0);
      end
    end
    step(0, 0, 0, 0);
    checkSmall("s3", bp, ba, bd, 1);

    // Scenario 4: two small frames back to back
    bp = pq1.size(); ba = nAcc[1]; bd = doneCnt[1];
    step(0, 0, 1, 0);
    bl = busyLow[1];
    for (int k = 1; k < 96; k++) step(0, 0, 1, 0);
    chk("s4_busyLowCycles", 1, busyLow[1] - bl, 2);
    step(0, 0, 0, 0);
    checkSmall("s4", bp, ba, bd, 2);

    // Scenario 5: clear together with pixel (3,5), then a full frame
    for (int k = 0; k < 29; k++) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("s5_validAfterClear", 1, ov[1], 0);
    chk("s5_busyAfterClear", 1, obusy[1], 0);
    bp = pq1.size(); ba = nAcc[1]; bd = doneCnt[1];
    for (int k = 0; k < 48; k++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    checkSmall("s5", bp, ba, bd, 1);

    // Scenario 6: asynchronous reset after 20 default pixels, then a full frame
    for (int k = 0; k < 20; k++) step(1, 0, 0, 0);
    chk("s6_busyBeforeReset", 0, obusy[0], 1);
    #2 rstn = 1'b0;
    #1 checkZeros("s6_async", 0);
    #1 rstn = 1'b1;
    bp = pq0.size(); ba = nAcc[0]; bd = doneCnt[0];
    for (int k = 0; k < 1024; k++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    checkBig("s6", bp, ba, bd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_win_ctrl.md
# conv_win_ctrl

Window-position controller for streaming 2-D convolution with independent frame width/height, window size and stride. It counts raster-order pixels accepted on iValid and flags each pixel that completes a stride-aligned WS×WS window (bottom-right corner). For each flagged pixel it also reports the output-map coordinate and frame markers. It sits beside the line buffer / MAC array and gates the result write into the output feature map.

## Interface
- XW, 32, input frame width in pixels (≥ WS)
- XH, 32, input frame height in pixels (≥ WS)
- WS, 5, square window size (≥ 1)
- STRIDE, 1, horizontal and vertical stride (≥ 1)
- CW, 6, counter/coordinate width; must satisfy 2^CW > max(XW, XH)

- iCLK  in  1  clock, rising edge
- iRSTn  in  1  reset, asynchronous, active-low
- iValid  in  1  one input pixel accepted this cycle
- iClear  in  1  synchronous frame abort/restart
- oValid  out  1  window complete at the pixel accepted one cycle earlier
- oRow  out  CW  output-map row of the current oValid, 0..OH-1
- oCol  out  CW  output-map column of the current oValid, 0..OW-1
- oSof  out  1  qualifies the first oValid of a frame (oRow=0, oCol=0)
- oEof  out  1  qualifies the last oValid of a frame (oRow=OH-1, oCol=OW-1)
- oFrameDone  out  1  one-cycle pulse after input pixel (XH-1, XW-1) is accepted
- oBusy  out  1  high while a frame is partially received

## Operation
- Derived constants: OW = (XW-WS)/STRIDE+1 and OH = (XH-WS)/STRIDE+1, using integer division.
- Input pixel counters x (column) and y (row) are CW bits and reset to 0. They advance only on iValid=1.
  - x wraps XW-1 → 0, and y increments on that wrap.
  - y wraps XH-1 → 0 together with x.
- Target counters xn and yn reset to WS-1.
  - A pixel hits when x==xn and y==yn.
  - On a hit, xn += STRIDE, and oc increments.
  - When xn+STRIDE > XW-1, or at the end of a row, xn reloads WS-1 at the row wrap and oc reloads 0.
  - yn += STRIDE and or increments when a hitting row completes.
  - When the frame completes, yn reloads WS-1 and or reloads 0.
- The combinational compare therefore never needs a modulo. A pixel qualifies iff all of the following hold:
  - x ≥ WS-1 and y ≥ WS-1
  - (x-WS+1) % STRIDE == 0 and (y-WS+1) % STRIDE == 0
  - x ≤ WS-1+(OW-1)·STRIDE and y ≤ WS-1+(OH-1)·STRIDE
- Trailing columns and rows that cannot hold a full stride-aligned window produce no oValid.
- FSM has two states:
  - IDLE (oBusy=0): waits for a pixel. The first iValid moves to RUN.
  - RUN (oBusy=1): accepting pixel (XH-1, XW-1) returns to IDLE and sets oFrameDone the next cycle.
  - iClear returns to IDLE from either state.
- iClear resets x, y, xn, yn, or and oc. It deasserts oValid, oSof and oEof on the next edge. iClear has priority over a simultaneous iValid: that pixel is dropped.
- Idle cycles (iValid=0) hold all counters. The output is a pure function of the accepted-pixel sequence, independent of gaps.

## Timing
- Reset values: oValid=0, oRow=0, oCol=0, oSof=0, oEof=0, oFrameDone=0, oBusy=0. Counters are at their reset values and the FSM is in IDLE.
- Latency: iValid on the cycle the hitting pixel is accepted → oValid, oRow, oCol, oSof and oEof registered one cycle later.
- oValid is high for exactly one cycle per hitting pixel. With back-to-back pixels and STRIDE=1, oValid may be high on consecutive cycles.
- oRow, oCol, oSof and oEof are meaningful only while oValid=1. They hold their last value otherwise.
- oFrameDone is asserted in the same cycle as the final oEof when the last pixel is a hit, for example when (XW-WS) and (XH-WS) are both multiples of STRIDE.
- Frames run back to back: the pixel following (XH-1, XW-1) is (0, 0) of the next frame with no dead cycle.
- Asynchronous reset mid-frame returns to the full reset state immediately. The next pixel is treated as (0, 0).

## Test plan
- **Default parameters (32, 32, 5, 1), one contiguous frame of 1024 pixels.** Expect 784 oValid pulses.
  - First pulse at input index 4·32+4=132, with oRow=0, oCol=0, oSof=1.
  - Last pulse with oRow=27, oCol=27, oEof=1.
  - oFrameDone pulses once, in the same cycle as oEof.
- **XW=8, XH=6, WS=3, STRIDE=2.** Expect 6 pulses, at input (y, x) = (2,2), (2,4), (2,6), (4,2), (4,4), (4,6).
  - Column 7 and row 5 produce none.
  - oEof occurs at (4,6). oFrameDone follows the pixel at (5,7).
- **Scenario 2 with random iValid gaps (≈50% duty).** Identical pulse sequence and coordinates to scenario 2. Each oValid arrives exactly 1 cycle after its hitting pixel.
- **Scenario 2, two frames back to back.** 12 pulses total. The second frame's oSof coincides with (2,2) of frame 2. oBusy stays 1 across the boundary except the single IDLE transition.
- **iClear asserted together with iValid at pixel (3,5) in scenario 2, then a full frame.** That pixel is dropped. The next frame yields exactly 6 pulses starting at oRow=0, oCol=0.
- **iRSTn pulsed low after 20 pixels of scenario 1.** All outputs are 0 immediately. A subsequent full frame matches scenario 1 exactly.
